fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: 1-cycle-latency instruction fetch with a small {instr, pc} buffer.
// Redirects flush the buffer and the in-flight response, restarting fetch at once.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_addr_prev_o,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_O = OW'(BUF_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          inf_q, inf_d;
  logic [31:0]   inf_pc_q, inf_pc_d;
  logic [31:0]   prev_q;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   fi_instr_q [BUF_DEPTH];
  logic [31:0]   fi_pc_q [BUF_DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [OW-1:0] occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign instr_valid_o   = (cnt_q != '0);
  assign instr_o         = fi_instr_q[rd_q];
  assign instr_pc_o      = fi_pc_q[rd_q];
  assign mem_addr_prev_o = prev_q;

  assign pop  = instr_valid_o & instr_ready_i;
  assign push = inf_q & ~redirect_i;
  // occupancy once this cycle's pop retires, counting the response in flight
  assign occ  = OW'(cnt_q) + OW'(inf_q) - OW'(pop);

  assign issue      = redirect_i | (occ < DEPTH_O);
  assign mem_en_o   = issue & ~rst_i;
  assign mem_addr_o = rst_i      ? RESET_PC      :
                      redirect_i ? redirect_pc_i : pc_q;

  // next fetch PC and in-flight tracking
  always_comb begin
    pc_d     = pc_q;
    inf_d    = issue;
    inf_pc_d = inf_pc_q;
    if (issue) begin
      pc_d     = mem_addr_o + 32'd4;
      inf_pc_d = mem_addr_o;
    end
  end

  // buffer pointers and occupancy; a redirect empties the buffer
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (redirect_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (pop)  rd_d = ptr_inc(rd_q);
      if (push) wr_d = ptr_inc(wr_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // control state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      inf_q    <= 1'b0;
      inf_pc_q <= RESET_PC;
      prev_q   <= RESET_PC;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      inf_q    <= inf_d;
      inf_pc_q <= inf_pc_d;
      prev_q   <= mem_addr_o;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
    end
  end

  // buffer storage; validity is tracked by cnt_q so no reset needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      fi_instr_q[wr_q] <= mem_rdata_i;
      fi_pc_q[wr_q]    <= inf_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam logic [31:0] K    = 32'hA5A5_A5A5;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redir = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        ready = 1'b0;
  bit          chk_on = 1'b0;

  logic        en, valid;
  logic [31:0] addr, prev, instr, ipc, rdata, ra_q;
  logic        en2, valid2;
  logic [31:0] addr2, prev2, instr2, ipc2, rdata2, ra2_q;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk_i(clk), .rst_i(rst),
    .redirect_i(redir), .redirect_pc_i(rpc),
    .mem_en_o(en), .mem_addr_o(addr),
    .mem_addr_prev_o(prev), .mem_rdata_i(rdata),
    .instr_valid_o(valid), .instr_ready_i(ready),
    .instr_o(instr), .instr_pc_o(ipc)
  );

  fetch_unit #(.RESET_PC(RPC2)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .mem_en_o(en2), .mem_addr_o(addr2),
    .mem_addr_prev_o(prev2), .mem_rdata_i(rdata2),
    .instr_valid_o(valid2), .instr_ready_i(1'b1),
    .instr_o(instr2), .instr_pc_o(ipc2)
  );

  // code memory: data = address ^ K, one cycle after the address
  always_ff @(posedge clk) begin
    ra_q  <= addr;
    ra2_q <= addr2;
  end
  assign rdata  = ra_q ^ K;
  assign rdata2 = ra2_q ^ K;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state: buffered PCs in order, one in-flight fetch
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_inf_pc = 32'h0;
  logic [31:0] m_prev = 32'h0;
  bit          m_inf = 1'b0;
  logic [31:0] m_q[$];

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [31:0] prev;
    logic        valid;
    logic [31:0] ipc;
  } mo_t;

  function automatic mo_t mdl();
    mo_t o;
    logic pop;
    o.valid = !rst && (m_q.size() != 0);
    pop     = o.valid && ready;
    o.addr  = rst ? 32'h0 : (redir ? rpc : m_pc);
    o.en    = !rst && (redir ||
              (m_q.size() + int'(m_inf) - int'(pop)) < 2);
    o.prev  = rst ? 32'h0 : m_prev;
    o.ipc   = o.valid ? m_q[0] : 32'h0;
    return o;
  endfunction

  initial begin : model_update
    mo_t o;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_pc = 32'h0;
        m_inf = 1'b0;
        m_inf_pc = 32'h0;
        m_prev = 32'h0;
        m_q.delete();
      end else begin
        o = mdl();
        if (o.valid && ready) void'(m_q.pop_front());
        if (redir) m_q.delete();
        else if (m_inf) m_q.push_back(m_inf_pc);
        m_inf = o.en;
        if (o.en) begin
          m_inf_pc = o.addr;
          m_pc = o.addr + 32'd4;
        end
        m_prev = o.addr;
      end
    end
  end

  // per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    mo_t e;
    if (chk_on) begin
      e = mdl();
      chk("mem_en", 32'(en), 32'(e.en));
      chk("mem_addr", addr, e.addr);
      chk("addr_prev", prev, e.prev);
      chk("instr_valid", 32'(valid), 32'(e.valid));
      if (e.valid) begin
        chk("instr_pc", ipc, e.ipc);
        chk("instr", instr, e.ipc ^ K);
      end
      chk("buf_bound", 32'(u_dut.cnt_q <= 2'd2), 32'd1);
      chk("mdl_bound", 32'(m_q.size() <= 2), 32'd1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    mo_t m;
    int  nf;
    rst = 1'b1;
    ready = 1'b1;
    repeat (3) cyc();
    chk_on = 1'b1;
    #2;
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_prev", prev, 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_addr2", addr2, RPC2);
    chk("rst_prev2", prev2, RPC2);

    // free-running stream from reset
    cyc(); rst = 1'b0; #2;
    m = mdl();
    chk("s1_en", 32'(en), 32'd1);
    chk("s1_addr", addr, 32'h0);
    chk("s1_mdl_addr", m.addr, 32'h0);
    chk("s1_addr2", addr2, 32'hFFFF_FFF8);
    cyc(); #2;
    chk("s2_addr", addr, 32'h4);
    chk("s2_valid", 32'(valid), 32'd0);
    chk("s2_addr2", addr2, 32'hFFFF_FFFC);
    cyc(); #2;
    m = mdl();
    chk("s3_valid", 32'(valid), 32'd1);
    chk("s3_pc", ipc, 32'h0);
    chk("s3_instr", instr, 32'hA5A5_A5A5);
    chk("s3_mdl_pc", m.ipc, 32'h0);
    chk("s3_addr2", addr2, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc(); #2;
      chk("s_valid", 32'(valid), 32'd1);
      chk("s_pc", ipc, 32'(4 * k));
      chk("s_instr", instr, 32'(4 * k) ^ K);
    end

    // consumer stalled from reset
    rst = 1'b1;
    cyc(); ready = 1'b0;
    cyc(); rst = 1'b0;
    nf = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      if (en) nf++;
      if (i >= 2) begin
        chk("stall_valid", 32'(valid), 32'd1);
        chk("stall_pc", ipc, 32'h0);
      end
      cyc();
    end
    chk("stall_fetches", 32'(nf), 32'd2);
    ready = 1'b1; #2;
    chk("drain_pc0", ipc, 32'h0);
    chk("drain_en", 32'(en), 32'd1);
    chk("drain_addr", addr, 32'h8);
    cyc(); #2;
    chk("drain_pc4", ipc, 32'h4);
    cyc(); #2;
    chk("drain_pc8", ipc, 32'h8);

    // redirect with buffer plus in-flight at capacity
    rst = 1'b1;
    cyc(); ready = 1'b0;
    cyc(); rst = 1'b0; #2;
    cyc(); #2;
    chk("r_pre_addr", addr, 32'h4);
    cyc(); redir = 1'b1; rpc = 32'h100; #2;
    chk("r_addr", addr, 32'h100);
    chk("r_en", 32'(en), 32'd1);
    cyc(); redir = 1'b0; ready = 1'b1; #2;
    chk("r_flushed", 32'(valid), 32'd0);
    chk("r_next_addr", addr, 32'h104);
    cyc(); #2;
    chk("r_pc100", ipc, 32'h100);
    chk("r_instr100", instr, 32'h100 ^ K);
    cyc(); #2;
    chk("r_pc104", ipc, 32'h104);

    // misaligned redirect coinciding with a pop from a full buffer
    cyc(); ready = 1'b0;
    repeat (4) cyc();
    ready = 1'b1; redir = 1'b1; rpc = 32'h202; #2;
    chk("m_valid", 32'(valid), 32'd1);
    chk("m_addr", addr, 32'h202);
    chk("m_en", 32'(en), 32'd1);
    cyc(); redir = 1'b0; #2;
    chk("m_prev", prev, 32'h202);
    chk("m_addr206", addr, 32'h206);
    chk("m_flushed", 32'(valid), 32'd0);
    cyc(); #2;
    chk("m_pc202", ipc, 32'h202);
    chk("m_instr202", instr, 32'h202 ^ K);
    cyc(); #2;
    chk("m_pc206", ipc, 32'h206);

    // asynchronous reset with two entries buffered
    cyc(); ready = 1'b0;
    repeat (3) cyc();
    #2;
    chk("a_pre_valid", 32'(valid), 32'd1);
    rst = 1'b1; #1;
    chk("a_valid", 32'(valid), 32'd0);
    chk("a_en", 32'(en), 32'd0);
    chk("a_addr", addr, 32'h0);
    cyc(); cyc(); rst = 1'b0; #2;
    chk("a_re_en", 32'(en), 32'd1);
    chk("a_re_addr", addr, 32'h0);
    cyc(); cyc(); #2;
    chk("a_re_pc", ipc, 32'h0);
    chk("a_re_valid", 32'(valid), 32'd1);

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
